bg_block_mem_ctrl: RTL and testbench

Memory-side partner of the GPU backend's background-block cache. It watches the backend's 2-bit block-operation code and snapshots the exported 256-bit block and its 16-bit pixel mask. It writes the masked pixels back to VRAM in 8 × 32-bit beats, then reads the next block in 8 beats and delivers it to the backend in a single-cycle import pulse. It also generates the backend's mask-reset and state-spike-reset pulses and a busy signal used to pause the pipeline.

---
 rtl/bg_block_mem_ctrl.sv | 150 +++++++++++++++
 tb/tb_bg_block_mem_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_block_mem_ctrl.sv
// Memory-side partner of the background-block cache: snapshots an exported block,
// writes its masked pixels back to VRAM beat by beat, then loads and imports the next block.
module bg_block_mem_ctrl #(
  parameter int BEATS = 8
) (
  input  logic         clk,
  input  logic         i_nrst,
  input  logic [1:0]   i_saveBGBlock,
  input  logic [14:0]  i_loadAdr,
  input  logic [14:0]  i_saveAdr,
  input  logic [255:0] i_exportedBGBlock,
  input  logic [15:0]  i_exportedMSKBGBlock,
  input  logic         i_skipLoad,
  output logic         o_busy,
  output logic         o_resetPipelinePixelStateSpike,
  output logic         o_resetPixelMask,
  output logic         o_importBGBlockSingleClock,
  output logic [255:0] o_importedBGBlock,
  output logic         o_memReq,
  output logic         o_memWrite,
  output logic [17:0]  o_memAdr,
  output logic [31:0]  o_memWdata,
  output logic [3:0]   o_memByteEn,
  input  logic         i_memAck,
  input  logic [31:0]  i_memRdata
);

  typedef enum logic [2:0] {IDLE, SNAP, WRITE, READ, IMPORT, DONE} state_t;

  localparam logic [2:0] LAST = 3'(BEATS - 1);

  state_t         state, state_nx;
  logic [2:0]     beat, beat_nx;
  logic           armed;
  logic           accept;
  logic [1:0]     code_q;
  logic [14:0]    save_q, load_q;
  logic [255:0]   blk_q;
  logic [15:0]    msk_q;
  logic [1:0]     pair;
  logic           advance;

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state             <= IDLE;
      beat              <= '0;
      armed             <= 1'b1;
      code_q            <= '0;
      save_q            <= '0;
      load_q            <= '0;
      blk_q             <= '0;
      msk_q             <= '0;
      o_importedBGBlock <= '0;
    end else begin
      state <= state_nx;
      beat  <= beat_nx;
      // A held nonzero code is taken once; re-arming needs an intervening 00.
      if (i_saveBGBlock == 2'b00) armed <= 1'b1;
      else if (accept)            armed <= 1'b0;
      if (accept) begin
        code_q <= i_saveBGBlock;
        save_q <= i_saveAdr;
        load_q <= i_loadAdr;
        blk_q  <= i_exportedBGBlock;
        msk_q  <= i_exportedMSKBGBlock;
      end
      if (state == READ && i_memAck)
        o_importedBGBlock[{beat, 5'b0} +: 32] <= i_memRdata;
    end
  end

  always_comb begin
    accept = (state == IDLE) && (i_saveBGBlock != 2'b00) && armed;
    pair   = msk_q[{beat, 1'b0} +: 2];
  end

  always_comb begin
    state_nx                       = state;
    beat_nx                        = beat;
    advance                        = 1'b0;
    o_busy                         = 1'b0;
    o_resetPipelinePixelStateSpike = 1'b0;
    o_resetPixelMask               = 1'b0;
    o_importBGBlockSingleClock     = 1'b0;
    o_memReq                       = 1'b0;
    o_memWrite                     = 1'b0;
    o_memAdr                       = '0;
    o_memWdata                     = '0;
    o_memByteEn                    = '0;
    case (state)
      IDLE: begin
        beat_nx = '0;
        if (accept) state_nx = SNAP;
      end
      SNAP: begin
        o_busy                         = 1'b1;
        o_resetPixelMask               = 1'b1;
        o_resetPipelinePixelStateSpike = 1'b1;
        beat_nx                        = '0;
        if (code_q == 2'b01) state_nx = i_skipLoad ? DONE : READ;
        else                 state_nx = WRITE;
      end
      WRITE: begin
        o_busy = 1'b1;
        // Beats with no written pixel cost one idle cycle and never reach memory.
        if (pair == 2'b00) begin
          advance = 1'b1;
        end else begin
          o_memReq    = 1'b1;
          o_memWrite  = 1'b1;
          o_memAdr    = {save_q, beat};
          o_memWdata  = blk_q[{beat, 5'b0} +: 32];
          o_memByteEn = {pair[1], pair[1], pair[0], pair[0]};
          advance     = i_memAck;
        end
        if (advance) begin
          if (beat == LAST) begin
            beat_nx  = '0;
            state_nx = (code_q == 2'b10 && !i_skipLoad) ? READ : DONE;
          end else begin
            beat_nx = beat + 3'd1;
          end
        end
      end
      READ: begin
        o_busy   = 1'b1;
        o_memReq = 1'b1;
        o_memAdr = {load_q, beat};
        if (i_memAck) begin
          if (beat == LAST) begin
            beat_nx  = '0;
            state_nx = IMPORT;
          end else begin
            beat_nx = beat + 3'd1;
          end
        end
      end
      IMPORT: begin
        o_busy                     = 1'b1;
        o_importBGBlockSingleClock = 1'b1;
        state_nx                   = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bg_block_mem_ctrl.sv
// Directed bench for bg_block_mem_ctrl: table of commands with hand-computed beat counts
// and busy lengths, a stalling memory responder, plus hold, latency and reset sequences.
module tb_bg_block_mem_ctrl;

  logic         clk = 1'b0;
  logic         i_nrst = 1'b1;
  logic [1:0]   i_saveBGBlock = '0;
  logic [14:0]  i_loadAdr = '0;
  logic [14:0]  i_saveAdr = '0;
  logic [255:0] i_exportedBGBlock = '0;
  logic [15:0]  i_exportedMSKBGBlock = '0;
  logic         i_skipLoad = 1'b0;
  logic         o_busy;
  logic         o_resetPipelinePixelStateSpike;
  logic         o_resetPixelMask;
  logic         o_importBGBlockSingleClock;
  logic [255:0] o_importedBGBlock;
  logic         o_memReq;
  logic         o_memWrite;
  logic [17:0]  o_memAdr;
  logic [31:0]  o_memWdata;
  logic [3:0]   o_memByteEn;
  logic         i_memAck = 1'b0;
  logic [31:0]  i_memRdata = '0;

  bg_block_mem_ctrl #(.BEATS(8)) dut (
    .clk                            (clk),
    .i_nrst                         (i_nrst),
    .i_saveBGBlock                  (i_saveBGBlock),
    .i_loadAdr                      (i_loadAdr),
    .i_saveAdr                      (i_saveAdr),
    .i_exportedBGBlock              (i_exportedBGBlock),
    .i_exportedMSKBGBlock           (i_exportedMSKBGBlock),
    .i_skipLoad                     (i_skipLoad),
    .o_busy                         (o_busy),
    .o_resetPipelinePixelStateSpike (o_resetPipelinePixelStateSpike),
    .o_resetPixelMask               (o_resetPixelMask),
    .o_importBGBlockSingleClock     (o_importBGBlockSingleClock),
    .o_importedBGBlock              (o_importedBGBlock),
    .o_memReq                       (o_memReq),
    .o_memWrite                     (o_memWrite),
    .o_memAdr                       (o_memAdr),
    .o_memWdata                     (o_memWdata),
    .o_memByteEn                    (o_memByteEn),
    .i_memAck                       (i_memAck),
    .i_memRdata                     (i_memRdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  // observation state, cleared by the main sequence before each command
  int          n_rm, n_sp, n_imp, n_busy, n_wr, n_rd, stab_bad;
  int          rm_cyc, imp_cyc, fall_cyc;
  logic        seen_busy, busy_fell, hold_valid;
  logic [53:0] hold_sig;
  logic [17:0] wr_adr [16];
  logic [31:0] wr_dat [16];
  logic [3:0]  wr_be  [16];
  logic [17:0] rd_adr [16];
  int unsigned max_stall = 0;

  function automatic logic [31:0] rd_model(input logic [17:0] a);
    return {~a[13:0], a};
  endfunction

  function automatic logic [255:0] mk_blk(input int i);
    logic [255:0] b;
    for (int k = 0; k < 16; k++) b[16*k +: 16] = 16'(i * 4099 + k * 257 + 16'h0A01);
    return b;
  endfunction

  function automatic logic [59:0] outs_now();
    return {o_busy, o_resetPipelinePixelStateSpike, o_resetPixelMask,
            o_importBGBlockSingleClock, o_memReq, o_memWrite, o_memAdr,
            o_memWdata, o_memByteEn};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // memory responder: ack after 0..max_stall wait cycles, read data from rd_model
  initial begin
    logic        pending;
    int unsigned wait_cnt;
    pending  = 1'b0;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!o_memReq) begin
        i_memAck = 1'b0;
        pending  = 1'b0;
      end else begin
        if (!pending) begin
          pending  = 1'b1;
          wait_cnt = (max_stall == 0) ? 0 : $urandom_range(max_stall, 0);
        end
        if (wait_cnt == 0) begin
          i_memAck   = 1'b1;
          i_memRdata = rd_model(o_memAdr);
          pending    = 1'b0;
        end else begin
          i_memAck = 1'b0;
          wait_cnt--;
        end
      end
    end
  end

  // monitor, mid-cycle
  always @(negedge clk) begin
    if (o_resetPixelMask) begin n_rm++; rm_cyc = cyc; end
    if (o_resetPipelinePixelStateSpike) n_sp++;
    if (o_importBGBlockSingleClock) begin n_imp++; imp_cyc = cyc; end
    if (o_busy) begin
      n_busy++;
      seen_busy = 1'b1;
    end else if (seen_busy && !busy_fell) begin
      busy_fell = 1'b1;
      fall_cyc  = cyc;
    end
    if (o_memReq && i_memAck) begin
      if (o_memWrite) begin
        if (n_wr < 16) begin
          wr_adr[n_wr] = o_memAdr; wr_dat[n_wr] = o_memWdata; wr_be[n_wr] = o_memByteEn;
        end
        n_wr++;
      end else begin
        if (n_rd < 16) rd_adr[n_rd] = o_memAdr;
        n_rd++;
      end
    end
    if (hold_valid && o_memReq && {o_memAdr, o_memWdata, o_memByteEn} !== hold_sig) stab_bad++;
    hold_valid = o_memReq && !i_memAck;
    hold_sig   = {o_memAdr, o_memWdata, o_memByteEn};
  end

  task automatic clear_obs();
    n_rm = 0; n_sp = 0; n_imp = 0; n_busy = 0; n_wr = 0; n_rd = 0; stab_bad = 0;
    rm_cyc = -1; imp_cyc = -1; fall_cyc = -1;
    seen_busy = 1'b0; busy_fell = 1'b0; hold_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 400 && !busy_fell; t++) tick();
    chk("done_in_time", busy_fell, 1'b1);
    tick();
  endtask

  task automatic chk_reads(input string nm, input logic [14:0] la);
    logic [255:0] exp_blk;
    for (int b = 0; b < 8; b++) begin
      exp_blk[32*b +: 32] = rd_model({la, 3'(b)});
      if (b < n_rd) chk($sformatf("%s_rd_adr%0d", nm, b), rd_adr[b], {la, 3'(b)});
    end
    chk($sformatf("%s_import_blk", nm), o_importedBGBlock, exp_blk);
  endtask

  typedef struct {
    logic [1:0]  code;
    logic [15:0] mask;
    logic        skip;
    int unsigned stall;
    int          exp_wr;
    int          exp_rd;
    int          exp_imp;
    int          exp_busy;
  } vec_t;

  task automatic run_vec(input int i, input vec_t v);
    logic [255:0] blk;
    logic [14:0]  sa, la;
    logic [1:0]   pr;
    int           acc, idx;
    string        nm;
    nm  = $sformatf("v%0d", i);
    blk = mk_blk(i);
    sa  = 15'(15'h1000 + i * 3);
    la  = 15'(15'h2A00 + i * 5);
    clear_obs();
    max_stall            = v.stall;
    i_exportedBGBlock    = blk;
    i_exportedMSKBGBlock = v.mask;
    i_saveAdr            = sa;
    i_loadAdr            = la;
    i_skipLoad           = v.skip;
    i_saveBGBlock        = v.code;
    acc                  = cyc;
    tick();
    // backend reuses its cache right after the snapshot
    i_saveBGBlock        = 2'b00;
    i_exportedBGBlock    = ~blk;
    i_exportedMSKBGBlock = 16'hFFFF;
    wait_done();
    chk({nm, "_accepts"}, n_rm, 1);
    chk({nm, "_spikes"}, n_sp, 1);
    chk({nm, "_pulse_ofs"}, rm_cyc - acc, 1);
    chk({nm, "_n_wr"}, n_wr, v.exp_wr);
    chk({nm, "_n_rd"}, n_rd, v.exp_rd);
    chk({nm, "_n_imp"}, n_imp, v.exp_imp);
    chk({nm, "_stable"}, stab_bad, 0);
    if (v.stall == 0) begin
      chk({nm, "_busy_len"}, n_busy, v.exp_busy);
      chk({nm, "_fall_ofs"}, fall_cyc - acc, v.exp_busy + 1);
      if (v.exp_imp != 0) chk({nm, "_imp_ofs"}, imp_cyc - acc, v.exp_busy);
    end
    idx = 0;
    for (int b = 0; b < 8; b++) begin
      pr = v.mask[2*b +: 2];
      if (pr != 2'b00) begin
        if (idx < n_wr && idx < 16) begin
          chk($sformatf("%s_wr_adr%0d", nm, b), wr_adr[idx], {sa, 3'(b)});
          chk($sformatf("%s_wr_dat%0d", nm, b), wr_dat[idx], blk[32*b +: 32]);
          chk($sformatf("%s_wr_be%0d", nm, b), wr_be[idx], {pr[1], pr[1], pr[0], pr[0]});
        end
        idx++;
      end
    end
    if (v.exp_imp != 0) chk_reads(nm, la);
    i_skipLoad = 1'b0;
    max_stall  = 0;
  endtask

  vec_t vecs [8];

  initial begin
    logic found;
    vecs[0] = '{2'b01, 16'h0000, 1'b0, 0, 0, 8, 1, 10};
    vecs[1] = '{2'b10, 16'hFFFF, 1'b0, 0, 8, 8, 1, 18};
    vecs[2] = '{2'b11, 16'h0021, 1'b0, 0, 2, 0, 0, 9};
    vecs[3] = '{2'b10, 16'h0000, 1'b1, 0, 0, 0, 0, 9};
    vecs[4] = '{2'b11, 16'hFFFF, 1'b0, 0, 8, 0, 0, 9};
    vecs[5] = '{2'b01, 16'h0000, 1'b1, 0, 0, 0, 0, 1};
    vecs[6] = '{2'b10, 16'hFFFF, 1'b0, 5, 8, 8, 1, 0};
    vecs[7] = '{2'b10, 16'hC3A0, 1'b0, 3, 4, 8, 1, 0};

    clear_obs();
    #2 i_nrst = 1'b0;
    #1;
    chk("reset_outputs", outs_now(), '0);
    chk("reset_import_blk", o_importedBGBlock, '0);
    repeat (3) tick();
    i_nrst = 1'b1;
    repeat (2) tick();

    // code 01 held for 30 cycles is taken only once
    clear_obs();
    i_loadAdr     = 15'h3C1F;
    i_saveBGBlock = 2'b01;
    repeat (30) tick();
    i_saveBGBlock = 2'b00;
    wait_done();
    chk("hold_accepts", n_rm, 1);
    chk("hold_n_rd", n_rd, 8);
    chk("hold_n_wr", n_wr, 0);
    chk("hold_n_imp", n_imp, 1);
    chk_reads("hold", 15'h3C1F);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // reset during READ beat 4 aborts without an import pulse
    clear_obs();
    i_loadAdr     = 15'h0155;
    i_saveBGBlock = 2'b01;
    tick();
    i_saveBGBlock = 2'b00;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      if (o_memReq && !o_memWrite && o_memAdr[2:0] == 3'd4) found = 1'b1;
      else tick();
    end
    chk("rst_reached_beat4", found, 1'b1);
    i_nrst = 1'b0;
    #1;
    chk("rst_mid_outputs", outs_now(), '0);
    chk("rst_mid_import_blk", o_importedBGBlock, '0);
    n_imp = 0;
    repeat (5) tick();
    chk("rst_no_import", n_imp, 0);
    i_nrst = 1'b1;
    tick();
    run_vec(20, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
